// File: rtl/store_bus_ctrl.sv
// store_bus_ctrl: RV32 store-to-memory lane aligner; splits misaligned sh/sw into two word beats.
module store_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;
    state_t r_state, w_next;
    logic        w_store, w_legal, w_accept, w_illegal, w_split;
    logic [3:0]  w_mask;
    logic [31:0] w_data;
    logic [7:0]  w_be_wide;
    logic [63:0] w_data_wide;
    logic [31:0] r_b2_addr, r_b2_wdata;
    logic [3:0]  r_b2_be;
    logic        r_split;
    // Shifting into a double-width window yields both beats at once; the upper half is beat 2.
    always_comb begin
        req_ready   = r_state == IDLE;
        w_store     = opcode == 7'b0100011;
        w_legal     = ~funct3[2] & ~(funct3[1] & funct3[0]);
        w_accept    = req_valid & req_ready & w_store & w_legal;
        w_illegal   = req_valid & req_ready & w_store & ~w_legal;
        w_mask      = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 : 4'b0001;
        w_data      = funct3[1] ? wdata : funct3[0] ? {16'b0, wdata[15:0]} : {24'b0, wdata[7:0]};
        w_be_wide   = {4'b0, w_mask} << addr[1:0];
        w_data_wide = {32'b0, w_data} << {addr[1:0], 3'b000};
        w_split     = |w_be_wide[7:4];
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? FIRST : IDLE;
            FIRST:   w_next = mem_ack ? (r_split ? SECOND : IDLE) : FIRST;
            SECOND:  w_next = mem_ack ? IDLE : SECOND;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            r_b2_addr  <= '0;
            r_b2_wdata <= '0;
            r_b2_be    <= '0;
            r_split    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= w_illegal;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        mem_req    <= 1'b1;
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wdata  <= (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} : w_data_wide[31:0];
                        mem_be     <= w_be_wide[3:0];
                        r_b2_addr  <= {addr[31:2], 2'b00} + 32'd4;
                        r_b2_wdata <= w_data_wide[63:32];
                        r_b2_be    <= w_be_wide[7:4];
                        r_split    <= w_split;
                    end
                end
                FIRST: begin
                    if (mem_ack) begin
                        mem_req   <= r_split;
                        mem_addr  <= r_split ? r_b2_addr : '0;
                        mem_wdata <= r_split ? r_b2_wdata : '0;
                        mem_be    <= r_split ? r_b2_be : '0;
                        done      <= ~r_split;
                    end
                end
                SECOND: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/store_bus_ctrl.md
STORE_BUS_CTRL -- requirements
Module: store_bus_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (RV32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 opcode  input  7  instruction opcode; store = 7'b0100011.
REQ-007 funct3  input  3  000 sb, 001 sh, 010 sw.
REQ-008 addr  input  32  effective byte address.
REQ-009 wdata  input  32  store data, right-justified; sb uses [7:0], sh uses [15:0].
REQ-010 mem_req  output  1  data-memory write request, registered.
REQ-011 mem_addr  output  32  word-aligned write address, registered.
REQ-012 mem_wdata  output  32  lane-aligned write data, registered.
REQ-013 mem_be  output  4  byte enables; bit k = byte lane k.
REQ-014 mem_ack  input  1  memory accepted current beat.
REQ-015 done  output  1  one-cycle pulse: store fully written.
REQ-016 err  output  1  one-cycle pulse: illegal store funct3.

Function
REQ-017 States: IDLE, FIRST, SECOND; req_ready = 1 only in IDLE.
REQ-018 Accept: req_valid & req_ready & opcode==0100011 & funct3 in {000,001,010}; latch funct3, addr, wdata; go to FIRST.
REQ-019 Non-store opcode with req_valid in IDLE: ignored; no state change, no pulses.
REQ-020 Store opcode with funct3 not in {000,001,010} in IDLE: err = 1 the next cycle; stay IDLE; no mem_req.
REQ-021 Offset off = addr[1:0]; base = {addr[31:2],2'b00}.
REQ-022 sb: single beat; be = 0001<<off; data = byte replicated in all four lanes.
REQ-023 sh, off 0..2: single beat; be = 0011<<off; data = half<<(8*off).
REQ-024 sh, off 3: split; beat 1 be 1000, data byte3 = wdata[7:0]; beat 2 be 0001, data byte0 = wdata[15:8].
REQ-025 sw, off 0: single beat; be 1111; data = wdata.
REQ-026 sw, off k != 0: split; beat 1 be = (1111<<k)[3:0], data = wdata<<(8k); beat 2 be = 1111>>(4-k), data = wdata>>(8(4-k)).
REQ-027 Beat 1 address = base; beat 2 address = base+4 mod 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-028 mem_req rises the cycle after accept; mem_addr, mem_wdata and mem_be are stable while mem_req=1 and mem_ack=0.
REQ-029 FIRST & mem_ack: if split, go to SECOND with beat-2 outputs the next cycle; otherwise go to IDLE.
REQ-030 SECOND & mem_ack: go to IDLE.
REQ-031 Final ack: the next cycle has mem_req=0, done=1, req_ready=1; minimum latency is accept at edge N, done in cycle N+2 (single beat) or N+3 (split).
REQ-032 mem_req=0: mem_addr, mem_wdata and mem_be are 0.
REQ-033 mem_ack while mem_req=0 is ignored.
REQ-034 Inputs are ignored outside IDLE; no request queuing.
REQ-035 done and err are never asserted together.

Reset
REQ-036 reset=1 at edge: state IDLE; mem_req, mem_addr, mem_wdata, mem_be, done, err = 0; req_ready=1 the next cycle.
REQ-037 Reset mid-transaction abandons the store; no done pulse; a pending beat is dropped.

Verification
REQ-038 sw addr 0x100, wdata 0x5C3D5467, ack immediate -> one beat: addr 0x100, be 1111, data 0x5C3D5467; done 2 cycles after accept.
REQ-039 sb addr 0x203, wdata 0x00000067 -> addr 0x200, be 1000, data 0x67676767; single beat.
REQ-040 sw addr 0x102, wdata 0x5C3D5467 -> beat 1: addr 0x100, be 1100, data 0x54670000; beat 2: addr 0x104, be 0011, data 0x00005C3D; one done pulse.
REQ-041 sh addr 0x107, wdata 0x00005467, ack delayed 3 cycles per beat -> beat 1: addr 0x104, be 1000, data 0x67000000, held 3 cycles; beat 2: addr 0x108, be 0001, data 0x00000054.
REQ-042 sw addr 0xFFFFFFFE -> beat 2 addr 0x00000000, be 0011; and funct3=011 with store opcode -> err pulse, no mem_req; opcode 0000011 -> no response.
REQ-043 reset asserted while waiting for ack in FIRST -> next cycle mem_req=0, req_ready=1, no done.
